ebpc_out_arbiter: RTL
=====================

# ebpc_out_arbiter

Merges the two output streams of `ebpc_encoder` (BPC and ZNZ) into one stream for a single downstream consumer (packer/DMA write port). Uses burst-locked round-robin between the streams, tags every output beat with its source, and keeps per-stream delivered-beat counters. A single output register gives one cycle of latency and full throughput.

## Interface
- `DATA_W`, 8: width of all data buses; matches `ebpc_pkg::DATA_W`.
- `BURST_LEN`, 8: maximum beats per grant; must be ≥ 2.
- `CNT_W`, 32: width of the per-stream beat counters.

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active-low.
- `bpc_data_i` in DATA_W: BPC stream data.
- `bpc_vld_i` in 1: BPC valid.
- `bpc_rdy_o` out 1: BPC ready.
- `znz_data_i` in DATA_W: ZNZ stream data.
- `znz_vld_i` in 1: ZNZ valid.
- `znz_rdy_o` out 1: ZNZ ready.
- `data_o` out DATA_W: merged data.
- `src_o` out 1: source tag of `data_o`; 0 = BPC, 1 = ZNZ.
- `vld_o` out 1: merged valid.
- `rdy_i` in 1: merged ready.
- `clr_i` in 1: synchronous clear of both counters.
- `bpc_cnt_o` out CNT_W: BPC beats delivered on the output.
- `znz_cnt_o` out CNT_W: ZNZ beats delivered on the output.

## Operation
- **Grant FSM.** Two states, GNT_BPC and GNT_ZNZ. Reset state is GNT_BPC.
- **Burst counter.** `beat_q` has width clog2(BURST_LEN). It counts beats accepted from the granted source and is reset to 0 on every grant change.
- **Output register.** `take = !vld_o || rdy_i`.
  - `bpc_rdy_o = (state==GNT_BPC) && take`.
  - `znz_rdy_o = (state==GNT_ZNZ) && take`.
  - The non-granted ready is always 0.
- **Accept.** Granted vld && granted rdy. On accept: the output register loads data and `src_o <= state`, and `vld_o <= 1`. Otherwise, if `rdy_i` is high, `vld_o <= 0`. Data is held while `vld_o && !rdy_i`.
- **Burst end by count.** An accept occurs with `beat_q == BURST_LEN-1`.
  - If the other source's vld is high that cycle, switch grant.
  - Otherwise keep the grant.
  - In both cases `beat_q <= 0`.
- **Yield.** In a cycle where the granted vld is 0 and the other vld is 1, switch grant at the next edge and set `beat_q <= 0`. No beat is accepted in that cycle, so each yield costs exactly one bubble.
- **Both idle.** Granted vld = 0 and other vld = 0: the state and `beat_q` are held.
- **Backpressure.** While `take` = 0 no accept occurs and `beat_q` holds. Burst-end-by-count needs an accept, so it cannot fire. A yield can still fire.
- **Counters.** Each counter increments by 1 on an output handshake (`vld_o && rdy_i`) for the source in `src_o`. Counters saturate at 2^CNT_W−1.
  - `clr_i` has priority: counters go to 0.
  - If an output handshake occurs in the same cycle as `clr_i`, the matching counter becomes 1 and the other becomes 0.
- **Stream boundaries.** No frame or last handling. Each stream's beat order is preserved. Interleaving is visible only through `src_o`.

## Timing
- **Reset values.**
  - `vld_o` = 0, `data_o` = 0, `src_o` = 0.
  - `bpc_cnt_o` = 0, `znz_cnt_o` = 0.
  - State GNT_BPC, `beat_q` = 0.
  - Hence `bpc_rdy_o` = 1 and `znz_rdy_o` = 0 while in reset.
- **Latency.** A beat accepted at edge n appears on `data_o`/`vld_o` after edge n.
- **Throughput.** 1 beat/cycle while `rdy_i` = 1 and the granted source streams. There is no bubble on a count-triggered switch.
- **Ready paths.** `*_rdy_o` depend combinationally on `rdy_i` and registered state only; there is no combinational path from `*_vld_i`. All other outputs are registered.
- **Async reset mid-burst.** Any pending output beat is dropped (`vld_o` = 0), counters clear and the grant returns to BPC immediately. Upstream must be reset together with this block.

## Test plan
- **Single stream.** Reset, then BPC-only stream 0x01..0x14 (20 beats) with `rdy_i` = 1. Required: output equals the input order, `src_o` = 0 throughout, `bpc_cnt_o` = 20, `znz_cnt_o` = 0, first `vld_o` one cycle after the first accept.
- **Both continuously valid, BURST_LEN = 8.** BPC sends 0x00..0x17 (24 beats) and ZNZ sends 0x80..0x97 (24 beats), `rdy_i` = 1. Required: `src_o` pattern of 8×0, 8×1, 8×0, … ending in 8×1, with no idle cycles between bursts. Final counts are 24 and 24.
- **Yield.** BPC sends 3 beats then drops vld while ZNZ is valid. Required: exactly one bubble cycle, then ZNZ beats. `beat_q` restarts, so ZNZ gets a full 8-beat burst.
- **Backpressure.** Random `rdy_i` (0–3 wait cycles) with random source stalls over 1000 beats per stream. Required: no beat lost or duplicated, `data_o` stable while `vld_o && !rdy_i`, per-source order preserved, and counters equal the scoreboard.
- **Counter clear/saturation.** Pulse `clr_i` on the same cycle as a ZNZ output handshake: `znz_cnt_o` = 1 and `bpc_cnt_o` = 0. With CNT_W = 4, send 20 BPC beats: `bpc_cnt_o` holds 15.
- **Reset mid-burst.** Assert `rst_ni` while `vld_o` = 1, `rdy_i` = 0 and grant = ZNZ. Required: outputs go to reset values immediately, and after release the grant is BPC.

Source files
------------

// File: rtl/ebpc_out_arbiter.sv
// Merges the BPC and ZNZ encoder streams into one tagged stream using
// burst-locked round-robin, with per-stream delivered-beat counters.
module ebpc_out_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] bpc_data_i,
    input  logic              bpc_vld_i,
    output logic              bpc_rdy_o,
    input  logic [DATA_W-1:0] znz_data_i,
    input  logic              znz_vld_i,
    output logic              znz_rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              src_o,
    output logic              vld_o,
    input  logic              rdy_i,
    input  logic              clr_i,
    output logic [CNT_W-1:0]  bpc_cnt_o,
    output logic [CNT_W-1:0]  znz_cnt_o
);
    localparam int                BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {GNT_BPC = 1'b0, GNT_ZNZ = 1'b1} gnt_e;

    gnt_e              r_state, w_state_nxt;
    logic [BEAT_W-1:0] r_beat, w_beat_nxt;
    logic              r_vld;
    logic [DATA_W-1:0] r_data;
    logic              r_src;
    logic [CNT_W-1:0]  r_bpc_cnt, r_znz_cnt;

    logic              w_take, w_gnt_vld, w_oth_vld, w_accept, w_hs;
    logic [DATA_W-1:0] w_gnt_data;

    // Ready depends only on registered state and rdy_i, never on the valids.
    assign w_take     = !r_vld || rdy_i;
    assign bpc_rdy_o  = (r_state == GNT_BPC) && w_take;
    assign znz_rdy_o  = (r_state == GNT_ZNZ) && w_take;

    assign w_gnt_vld  = (r_state == GNT_ZNZ) ? znz_vld_i  : bpc_vld_i;
    assign w_oth_vld  = (r_state == GNT_ZNZ) ? bpc_vld_i  : znz_vld_i;
    assign w_gnt_data = (r_state == GNT_ZNZ) ? znz_data_i : bpc_data_i;
    assign w_accept   = w_gnt_vld && w_take;
    assign w_hs       = r_vld && rdy_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= GNT_BPC;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // A count-triggered switch happens on the accepting edge (no bubble);
    // a yield needs an idle granted source, so it always costs one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        if (w_accept) begin
            if (r_beat == LAST_BEAT) begin
                w_beat_nxt = '0;
                if (w_oth_vld) w_state_nxt = (r_state == GNT_BPC) ? GNT_ZNZ : GNT_BPC;
            end else begin
                w_beat_nxt = r_beat + BEAT_W'(1);
            end
        end else if (!w_gnt_vld && w_oth_vld) begin
            w_state_nxt = (r_state == GNT_BPC) ? GNT_ZNZ : GNT_BPC;
            w_beat_nxt  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_src  <= 1'b0;
        end else if (w_accept) begin
            r_vld  <= 1'b1;
            r_data <= w_gnt_data;
            r_src  <= (r_state == GNT_ZNZ);
        end else if (rdy_i) begin
            r_vld  <= 1'b0;
        end
    end

    // Clear wins, but a handshake in the clearing cycle still counts as one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bpc_cnt <= '0;
            r_znz_cnt <= '0;
        end else if (clr_i) begin
            r_bpc_cnt <= CNT_W'(w_hs && !r_src);
            r_znz_cnt <= CNT_W'(w_hs &&  r_src);
        end else if (w_hs) begin
            if (!r_src && r_bpc_cnt != CNT_MAX) r_bpc_cnt <= r_bpc_cnt + CNT_W'(1);
            if ( r_src && r_znz_cnt != CNT_MAX) r_znz_cnt <= r_znz_cnt + CNT_W'(1);
        end
    end

    assign vld_o     = r_vld;
    assign data_o    = r_data;
    assign src_o     = r_src;
    assign bpc_cnt_o = r_bpc_cnt;
    assign znz_cnt_o = r_znz_cnt;

endmodule
